// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for LUT configuration readback: widths, readback FSM encoding,
// and helpers that split one tile configuration into its two .mem-file words.
package fpga_cfg_pkg;

  localparam int CFG_W        = 33;
  localparam int WORD_W       = 32;
  localparam int NUM_LUTS_DEF = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LO    = 3'd2,
    HI    = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5
  } rb_state_e;

  // Word 2k of a tile: the 32 truth-table bits.
  function automatic logic [WORD_W-1:0] lo_word(input logic [CFG_W-1:0] cfg);
    return WORD_W'(cfg);
  endfunction

  // Word 2k+1 of a tile: the mode bit, zero-extended.
  function automatic logic [WORD_W-1:0] hi_word(input logic [CFG_W-1:0] cfg);
    return WORD_W'(cfg >> WORD_W);
  endfunction

endpackage

// File: rtl/cfg_word_checksum.sv
// Running modulo-2^WORD_W sum of streamed configuration words; clear has priority over add.
module cfg_word_checksum #(
  parameter int WORD_W = fpga_cfg_pkg::WORD_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear_i,
  input  logic              add_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [WORD_W-1:0] sum_o
);

  logic [WORD_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_i) begin
      sum_d = sum_q + word_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/lut_cfg_readback.sv
// Streams every LUT tile's configuration out as .mem-layout words over a valid/ready port.
// Optional trailing checksum word is enabled by defining CFG_READBACK_CHECKSUM_EN.
module lut_cfg_readback
  import fpga_cfg_pkg::*;
#(
  parameter  int NUM_LUTS = NUM_LUTS_DEF,
  parameter  int CFG_W    = fpga_cfg_pkg::CFG_W,
  parameter  int WORD_W   = fpga_cfg_pkg::WORD_W,
  localparam int SEL_W    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [SEL_W-1:0]  lut_sel,
  input  logic [CFG_W-1:0]  lut_cfg,
  output logic [WORD_W-1:0] out_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_LUTS - 1);

  rb_state_e         state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              xfer;
  logic              last_tile;

  assign xfer      = valid_q & out_ready;
  assign last_tile = (sel_q == LAST_SEL);

`ifdef CFG_READBACK_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
  logic              csum_clr;
  logic              csum_add;

  // Only the tile words are summed; the checksum word itself is excluded.
  assign csum_clr = (state_q == IDLE) & start;
  assign csum_add = xfer & ((state_q == LO) | (state_q == HI));

  cfg_word_checksum #(.WORD_W(WORD_W)) u_csum (
    .clock   (clock),
    .reset_n (reset_n),
    .clear_i (csum_clr),
    .add_i   (csum_add),
    .word_i  (word_q),
    .sum_o   (sum)
  );
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cfg_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cfg_q   <= cfg_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = LO;
      LO:      if (xfer) state_d = HI;
      HI: begin
        if (xfer) begin
          if (!last_tile) begin
            state_d = FETCH;
          end else begin
`ifdef CFG_READBACK_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef CFG_READBACK_CHECKSUM_EN
      CSUM:    if (xfer) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs only move on a transfer, so a stalled word stays put.
  always_comb begin
    sel_d   = sel_q;
    cfg_d   = cfg_q;
    word_d  = word_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d  = '0;
          busy_d = 1'b1;
        end
      end
      FETCH: begin
        cfg_d   = lut_cfg;
        word_d  = lo_word(lut_cfg);
        valid_d = 1'b1;
      end
      LO: begin
        if (xfer) begin
          word_d = hi_word(cfg_q);
`ifndef CFG_READBACK_CHECKSUM_EN
          last_d = last_tile;
`endif
        end
      end
      HI: begin
        if (xfer) begin
          if (!last_tile) begin
            sel_d   = sel_q + SEL_W'(1);
            valid_d = 1'b0;
          end else begin
`ifdef CFG_READBACK_CHECKSUM_EN
            word_d  = sum + word_q;
            last_d  = 1'b1;
`else
            valid_d = 1'b0;
            last_d  = 1'b0;
`endif
          end
        end
      end
`ifdef CFG_READBACK_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
`endif
      DONE:    busy_d = 1'b0;
      default: ;
    endcase
  end

  assign lut_sel   = sel_q;
  assign out_word  = word_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = (state_q == DONE);

endmodule
